// File: rtl/tcp_pkg.sv
// rtl/tcp_pkg.sv - shared types, constants and header/checksum byte selectors for the TCP assembler
package tcp_pkg;

    localparam logic [15:0] TCP_HDR_BYTES = 16'd20;
    localparam logic [7:0]  IP_PROTO_TCP  = 8'h06;

    localparam int FLAG_FIN = 0;
    localparam int FLAG_SYN = 1;
    localparam int FLAG_RST = 2;
    localparam int FLAG_PSH = 3;
    localparam int FLAG_ACK = 4;
    localparam int FLAG_URG = 5;
    localparam int FLAG_ECE = 6;
    localparam int FLAG_CWR = 7;

    typedef enum logic [2:0] {IDLE, CSUM, FOLD, HDR, DATA} tcp_asm_state_t;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [7:0]  flags;
        logic [15:0] window;
        logic [15:0] urg_ptr;
        logic [15:0] payload_len;
        logic [15:0] payload_csum;
    } tcp_hdr_t;

    function automatic logic [7:0] hdr_byte(input tcp_hdr_t h, input logic [4:0] idx,
                                            input logic [3:0] off, input logic [15:0] csum);
        logic [7:0] b;
        case (idx)
            5'd0:    b = h.src_port[15:8];
            5'd1:    b = h.src_port[7:0];
            5'd2:    b = h.dst_port[15:8];
            5'd3:    b = h.dst_port[7:0];
            5'd4:    b = h.seq_num[31:24];
            5'd5:    b = h.seq_num[23:16];
            5'd6:    b = h.seq_num[15:8];
            5'd7:    b = h.seq_num[7:0];
            5'd8:    b = h.ack_num[31:24];
            5'd9:    b = h.ack_num[23:16];
            5'd10:   b = h.ack_num[15:8];
            5'd11:   b = h.ack_num[7:0];
            5'd12:   b = {off, 4'b0000};
            5'd13:   b = h.flags;
            5'd14:   b = h.window[15:8];
            5'd15:   b = h.window[7:0];
            5'd16:   b = csum[15:8];
            5'd17:   b = csum[7:0];
            5'd18:   b = h.urg_ptr[15:8];
            5'd19:   b = h.urg_ptr[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Pseudo-header words first, then the TCP header with its checksum field skipped.
    function automatic logic [15:0] csum_word(input tcp_hdr_t h, input logic [3:0] idx,
                                              input logic [3:0] off);
        logic [15:0] w;
        case (idx)
            4'd0:    w = h.src_ip[31:16];
            4'd1:    w = h.src_ip[15:0];
            4'd2:    w = h.dst_ip[31:16];
            4'd3:    w = h.dst_ip[15:0];
            4'd4:    w = {8'h00, IP_PROTO_TCP};
            4'd5:    w = TCP_HDR_BYTES + h.payload_len;
            4'd6:    w = h.src_port;
            4'd7:    w = h.dst_port;
            4'd8:    w = h.seq_num[31:16];
            4'd9:    w = h.seq_num[15:0];
            4'd10:   w = h.ack_num[31:16];
            4'd11:   w = h.ack_num[15:0];
            4'd12:   w = {off, 4'b0000, h.flags};
            4'd13:   w = h.window;
            4'd14:   w = h.urg_ptr;
            default: w = h.payload_csum;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/tcp_assembler_if.sv
// rtl/tcp_assembler_if.sv - descriptor, payload and segment stream signals of the TCP assembler
interface tcp_assembler_if;
    logic        hdr_valid_i;
    logic        hdr_ready_o;
    logic [31:0] src_ip_i;
    logic [31:0] dst_ip_i;
    logic [15:0] src_port_i;
    logic [15:0] dst_port_i;
    logic [31:0] seq_num_i;
    logic [31:0] ack_num_i;
    logic [7:0]  flags_i;
    logic [15:0] window_i;
    logic [15:0] urg_ptr_i;
    logic [15:0] payload_len_i;
    logic [15:0] payload_csum_i;
    logic [7:0]  in_data_i;
    logic        in_valid_i;
    logic        in_last_i;
    logic        in_ready_o;
    logic [7:0]  out_data_o;
    logic        out_valid_o;
    logic        out_last_o;
    logic        out_ready_i;
    logic        len_err_o;

    modport master (
        output hdr_valid_i, src_ip_i, dst_ip_i, src_port_i, dst_port_i, seq_num_i, ack_num_i,
               flags_i, window_i, urg_ptr_i, payload_len_i, payload_csum_i,
               in_data_i, in_valid_i, in_last_i, out_ready_i,
        input  hdr_ready_o, in_ready_o, out_data_o, out_valid_o, out_last_o, len_err_o
    );

    modport slave (
        input  hdr_valid_i, src_ip_i, dst_ip_i, src_port_i, dst_port_i, seq_num_i, ack_num_i,
               flags_i, window_i, urg_ptr_i, payload_len_i, payload_csum_i,
               in_data_i, in_valid_i, in_last_i, out_ready_i,
        output hdr_ready_o, in_ready_o, out_data_o, out_valid_o, out_last_o, len_err_o
    );
endinterface

// File: rtl/tcp_csum16.sv
// rtl/tcp_csum16.sv - 16-bit one's-complement accumulator with clear, add and fold-to-checksum
module tcp_csum16 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_clear,
    input  logic        i_add,
    input  logic        i_fold,
    input  logic [15:0] i_word,
    output logic [15:0] o_csum
);
    logic [15:0] r_acc;
    logic [15:0] r_csum;
    logic [16:0] w_sum;

    assign w_sum  = {1'b0, r_acc} + {1'b0, i_word};
    assign o_csum = r_csum;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc  <= '0;
            r_csum <= '0;
        end else begin
            if (i_clear) begin
                r_acc <= '0;
            end else if (i_add) begin
                // End-around carry; the re-added carry can never overflow again.
                r_acc <= w_sum[15:0] + {15'd0, w_sum[16]};
            end
            if (i_fold) begin
                r_csum <= (r_acc == 16'hFFFF) ? 16'hFFFF : ~r_acc;
            end
        end
    end
endmodule

// File: rtl/tcp_assembler.sv
// rtl/tcp_assembler.sv - serialises a 20-byte TCP header plus payload; TCP_ASM_CSUM_EN enables checksum
module tcp_assembler
    import tcp_pkg::*;
#(
    parameter logic [3:0]  DATA_OFFSET = 4'd5,
    parameter logic [15:0] MAX_LEN     = 16'd1460
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    tcp_assembler_if.slave bus
);
    tcp_asm_state_t r_state, w_state_nxt;
    tcp_hdr_t       r_hdr;
    tcp_hdr_t       w_desc;
    logic [15:0]    r_cnt;
    logic           r_armed;
    logic [7:0]     r_out_data;
    logic           r_out_valid;
    logic           r_out_last;
    logic           r_len_err;

    logic        w_load;
    logic        w_hdr_ready;
    logic        w_hdr_fire;
    logic        w_hdr_emit;
    logic        w_hdr_last;
    logic [15:0] w_remaining;
    logic        w_in_ready;
    logic        w_in_fire;
    logic        w_final;
    logic [15:0] w_csum;

    assign w_desc = '{
        src_ip:       bus.src_ip_i,
        dst_ip:       bus.dst_ip_i,
        src_port:     bus.src_port_i,
        dst_port:     bus.dst_port_i,
        seq_num:      bus.seq_num_i,
        ack_num:      bus.ack_num_i,
        flags:        bus.flags_i,
        window:       bus.window_i,
        urg_ptr:      bus.urg_ptr_i,
        payload_len:  (bus.payload_len_i > MAX_LEN) ? MAX_LEN : bus.payload_len_i,
        payload_csum: bus.payload_csum_i
    };

    assign w_load      = !r_out_valid | bus.out_ready_i;
    // Holding ready low while any byte is still in the output register keeps segments from overlapping.
    assign w_hdr_ready = r_armed & (r_state == IDLE) & !r_out_valid;
    assign w_hdr_fire  = bus.hdr_valid_i & w_hdr_ready;
    assign w_hdr_emit  = (r_state == HDR) & w_load;
    assign w_hdr_last  = (r_cnt == TCP_HDR_BYTES - 16'd1);
    assign w_remaining = r_hdr.payload_len - r_cnt;
    assign w_in_ready  = (r_state == DATA) & w_load & (w_remaining != 16'd0);
    assign w_in_fire   = bus.in_valid_i & w_in_ready;
    assign w_final     = (w_remaining == 16'd1);

`ifdef TCP_ASM_CSUM_EN
    tcp_csum16 u_csum (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_clear (w_hdr_fire),
        .i_add   (r_state == CSUM),
        .i_fold  (r_state == FOLD),
        .i_word  (csum_word(r_hdr, r_cnt[3:0], DATA_OFFSET)),
        .o_csum  (w_csum)
    );
`else
    logic w_unused_csum;
    assign w_csum        = 16'h0000;
    assign w_unused_csum = ^{r_hdr.src_ip, r_hdr.dst_ip, r_hdr.payload_csum};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_hdr_fire) begin
`ifdef TCP_ASM_CSUM_EN
                    w_state_nxt = CSUM;
`else
                    w_state_nxt = HDR;
`endif
                end
            end
            CSUM:    if (r_cnt == 16'd15) w_state_nxt = FOLD;
            FOLD:    w_state_nxt = HDR;
            HDR: begin
                if (w_hdr_emit && w_hdr_last)
                    w_state_nxt = (r_hdr.payload_len == 16'd0) ? IDLE : DATA;
            end
            DATA:    if (w_in_fire && w_final) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hdr   <= '0;
            r_cnt   <= '0;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_hdr_fire) begin
                r_hdr <= w_desc;
                r_cnt <= '0;
            end else begin
                case (r_state)
                    CSUM:    r_cnt <= (r_cnt == 16'd15) ? 16'd0 : r_cnt + 16'd1;
                    HDR:     if (w_load) r_cnt <= w_hdr_last ? 16'd0 : r_cnt + 16'd1;
                    DATA:    if (w_in_fire) r_cnt <= r_cnt + 16'd1;
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    // Single output register; last comes only from the byte counter, in_last_i is only checked.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            if (w_hdr_emit) begin
                r_out_data  <= hdr_byte(r_hdr, r_cnt[4:0], DATA_OFFSET, w_csum);
                r_out_valid <= 1'b1;
                r_out_last  <= w_hdr_last & (r_hdr.payload_len == 16'd0);
            end else if (w_in_fire) begin
                r_out_data  <= bus.in_data_i;
                r_out_valid <= 1'b1;
                r_out_last  <= w_final;
                r_len_err   <= bus.in_last_i ^ w_final;
            end else if (bus.out_ready_i) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign bus.hdr_ready_o = w_hdr_ready;
    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_data_o  = r_out_data;
    assign bus.out_valid_o = r_out_valid;
    assign bus.out_last_o  = r_out_last;
    assign bus.len_err_o   = r_len_err;

endmodule

// File: doc/tcp_assembler.md
Name: tcp_assembler

Overview:
- Transmit-side counterpart of the TCP segment parser.
- Accepts one header descriptor per segment plus a byte-wide payload stream.
- Serialises a 20-byte TCP header (no options) followed by the payload, MSB-first, onto a byte stream handshake for the IP framing stage.
- Optionally computes the TCP checksum from the pseudo-header, the header and an upstream-supplied payload partial sum.

Parameters:
- DATA_OFFSET, 4'd5: header length in 32-bit words; fixed header, no options.
- MAX_LEN, 16'd1460: largest payload_len_i accepted; larger values are clamped to MAX_LEN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- hdr_valid_i  in  1  header descriptor valid
- hdr_ready_o  out  1  descriptor accepted when valid&ready
- src_ip_i / dst_ip_i  in  32 each  pseudo-header addresses
- src_port_i / dst_port_i  in  16 each  TCP ports
- seq_num_i / ack_num_i  in  32 each  sequence / acknowledgement numbers
- flags_i  in  8  CWR..FIN
- window_i  in  16  window size
- urg_ptr_i  in  16  urgent pointer
- payload_len_i  in  16  payload bytes, 0 allowed
- payload_csum_i  in  16  one's-complement partial sum of the payload (used only with the feature)
- in_data_i  in  8  payload byte
- in_valid_i  in  1  payload valid
- in_last_i  in  1  upstream end-of-payload marker
- in_ready_o  out  1  payload accept
- out_data_o  out  8  segment byte
- out_valid_o  out  1  segment byte valid
- out_last_o  out  1  final byte of segment
- out_ready_i  in  1  downstream accept
- len_err_o  out  1  one-cycle pulse on a payload length mismatch

Behaviour:
- Reset (async assert, sync deassert use):
  - hdr_ready_o=0, in_ready_o=0, out_valid_o=0, out_last_o=0, out_data_o=0, len_err_o=0, state=IDLE.
  - hdr_ready_o rises the first clock after rst_ni goes high.
- Reset mid-segment: outputs return to reset values immediately; the partial segment is dropped; no last is emitted.
- States:
  - IDLE: hdr_ready_o=1. On hdr_valid_i & hdr_ready_o, latch all descriptor fields, clear the byte counter, and move to CSUM (feature on) or HDR (feature off).
  - HDR: emit header bytes 0..19 in order:
    - bytes 0-1: src port; bytes 2-3: dst port; bytes 4-7: seq; bytes 8-11: ack.
    - byte 12 = {DATA_OFFSET,4'b0}; byte 13 = flags.
    - bytes 14-15: window; bytes 16-17: checksum; bytes 18-19: urgent pointer.
    - After byte 19 is accepted, go to DATA, or to IDLE if payload_len=0.
  - DATA: pass payload bytes through. After payload_len bytes are accepted, go to IDLE.
- Output stage is a single register:
  - It loads when !out_valid_o | out_ready_i.
  - out_data_o and out_last_o are held stable while out_valid_o & !out_ready_i.
- Payload handshake: in_ready_o = (state==DATA) & (!out_valid_o | out_ready_i) & (remaining>0). Payload is never accepted outside DATA.
- Throughput: one byte per cycle with out_ready_i held high. With the feature off, the first header byte is valid 1 cycle after descriptor acceptance.
- out_last_o comes from the byte counter only:
  - on header byte 19 when payload_len=0;
  - otherwise on the payload byte number payload_len.
- in_last_i is checked, never obeyed. len_err_o pulses when:
  - in_last_i=1 on an accepted byte that is not the final byte, or
  - in_last_i=0 on the final byte.
  - Byte counting continues regardless.
- Length: tcp_len = 20 + payload_len, in 16 bits. Clamping to MAX_LEN guarantees no wrap.
- hdr_ready_o=0 outside IDLE. A new descriptor is never accepted until the current last byte has been accepted downstream.

Optional Feature:
- Macro: TCP_ASM_CSUM_EN.
- Defined:
  - CSUM state accumulates 16 words, one per cycle: src IP hi/lo, dst IP hi/lo, 16'h0006, tcp_len, src port, dst port, seq hi/lo, ack hi/lo, {offset,flags}, window, urg_ptr, payload_csum_i.
  - The sum goes into a 17-bit end-around-carry adder.
  - A FOLD cycle follows; the emitted checksum is ~sum, and a result of 16'h0000 is emitted as 16'hFFFF.
  - The first header byte is valid 18 cycles after acceptance.
- Undefined: no CSUM/FOLD states; bytes 16-17 are 8'h00; payload_csum_i is ignored.

Decomposition:
- tcp_pkg holds:
  - tcp_hdr_t packed struct;
  - TCP_HDR_BYTES=20 and IP_PROTO_TCP=8'h06;
  - flag bit index constants FIN..CWR;
  - tcp_asm_state_t {IDLE, CSUM, FOLD, HDR, DATA}.
- Sub-module tcp_csum16: one's-complement accumulator with clear/add/fold. Instantiated only under TCP_ASM_CSUM_EN.

Test Plan:
- Feature off. Descriptor sport=0x1F90, dport=0x0050, seq=0x01020304, ack=0, flags=0x02 (SYN), window=0xFFFF, urg=0, len=0, with out_ready_i=1 -> 20 bytes 1F 90 00 50 01 02 03 04 00 00 00 00 50 02 FF FF 00 00 00 00, last on byte 19, hdr_ready_o low throughout.
- len=4, payload DE AD BE EF with in_last_i on EF -> 24 bytes; last only on EF; len_err_o stays 0; back in IDLE the next cycle.
- Same as the previous case, but out_ready_i toggles 1,0,0,1 repeatedly -> no byte lost or duplicated; out_data_o stable during stalls.
- len=4, in_last_i asserted on the 2nd byte -> len_err_o pulses once; 4 payload bytes still emitted; last on the 4th.
- TCP_ASM_CSUM_EN defined:
  - Known segment (src 192.168.0.1, dst 192.168.0.2, SYN as in the first case, payload_csum=0) -> bytes 16-17 match a reference model computed by the bench's one's-complement checksum routine.
  - Header byte 0 valid 18 cycles after acceptance.
- Drop rst_ni while payload byte 2 is in flight -> out_valid_o=0 asynchronously; after release, a fresh len=0 descriptor produces a clean 20-byte segment.
